// File: rtl/matmul_ctrl_regs_if.sv
// ============================================================================
// Module      : matmul_ctrl_regs_if
// Description : AXI-Lite slave bundle for the matmul control/status registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matmul_ctrl_regs_if #(
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

`default_nettype wire

// File: rtl/matmul_ctrl_regs.sv
// ============================================================================
// Module      : matmul_ctrl_regs
// Description : AXI-Lite CSR block sequencing the 2x2 matmul engine; optional
//               interrupt enabled by defining MATMUL_CTRL_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_ctrl_regs #(
    parameter int ADDR_W = 5,
    parameter int K_MAX  = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    matmul_ctrl_regs_if.slave s_axil,
    output logic [15:0]       o_cfg_k,
    output logic              o_start,
    input  wire logic         i_done,
    output logic              o_sw_clear_done,
    output logic              o_irq
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] c_IDX_CTRL  = IDX_W'(0);
    localparam logic [IDX_W-1:0] c_IDX_STAT  = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_CFGK  = IDX_W'(2);
    localparam logic [IDX_W-1:0] c_IDX_IRQEN = IDX_W'(3);
    localparam logic [IDX_W-1:0] c_IDX_JOB   = IDX_W'(4);

    logic        r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]  r_bresp;
    logic [31:0] r_rdata;
    logic        r_busy, r_done_st, r_err, r_start, r_clr;
    logic        r_done_q, r_done_q2;
    logic [15:0] r_cfg_k;
    logic [31:0] r_job_cnt;
    logic        r_irq_en;

    logic        w_wr_hs, w_rd_hs, w_done_rise, w_k_ok;
    logic        w_busy_nxt, w_done_nxt, w_err_nxt, w_start_nxt, w_clr_nxt, w_slverr;
    logic        w_irq_en_nxt;
    logic [15:0] w_cfg_k_nxt;
    logic [31:0] w_rd_data;
    logic [IDX_W-1:0] w_wr_idx, w_rd_idx;
    logic        w_unused_ok;

    assign w_wr_hs     = r_awready & s_axil.awvalid & s_axil.wvalid;
    assign w_rd_hs     = r_arready & s_axil.arvalid;
    assign w_wr_idx    = s_axil.awaddr[ADDR_W-1:2];
    assign w_rd_idx    = s_axil.araddr[ADDR_W-1:2];
    // Edge taken on the registered copy of done, so BUSY drops two cycles after done rises
    assign w_done_rise = r_done_q & ~r_done_q2 & r_busy;
    assign w_k_ok      = (r_cfg_k != 16'd0) && ({16'd0, r_cfg_k} <= 32'(K_MAX));
    assign w_unused_ok = ^{s_axil.awaddr[1:0], s_axil.araddr[1:0],
                           s_axil.wdata[31:16], s_axil.wstrb[3:2]};

    always_comb begin
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done_st;
        w_err_nxt    = r_err;
        w_cfg_k_nxt  = r_cfg_k;
        w_irq_en_nxt = r_irq_en;
        w_start_nxt  = 1'b0;
        w_clr_nxt    = 1'b0;
        w_slverr     = 1'b0;
        if (w_wr_hs) begin
            case (w_wr_idx)
                c_IDX_CTRL: begin
                    if (s_axil.wstrb[0]) begin
                        // CLEAR is applied before START so a combined write can restart
                        if (s_axil.wdata[1]) begin
                            w_clr_nxt  = 1'b1;
                            w_done_nxt = 1'b0;
                            w_err_nxt  = 1'b0;
                        end
                        if (s_axil.wdata[0]) begin
                            if (!r_busy && w_k_ok) begin
                                w_start_nxt = 1'b1;
                                w_busy_nxt  = 1'b1;
                                w_done_nxt  = 1'b0;
                            end else begin
                                w_err_nxt = 1'b1;
                                w_slverr  = 1'b1;
                            end
                        end
                    end
                end
                c_IDX_STAT: begin
                    if (s_axil.wstrb[0]) begin
                        if (s_axil.wdata[1]) w_done_nxt = 1'b0;
                        if (s_axil.wdata[2]) w_err_nxt  = 1'b0;
                    end
                end
                c_IDX_CFGK: begin
                    if (r_busy) begin
                        w_err_nxt = 1'b1;
                        w_slverr  = 1'b1;
                    end else begin
                        if (s_axil.wstrb[0]) w_cfg_k_nxt[7:0]  = s_axil.wdata[7:0];
                        if (s_axil.wstrb[1]) w_cfg_k_nxt[15:8] = s_axil.wdata[15:8];
                    end
                end
`ifdef MATMUL_CTRL_IRQ_EN
                c_IDX_IRQEN: begin
                    if (s_axil.wstrb[0]) w_irq_en_nxt = s_axil.wdata[0];
                end
`endif
                default: ;
            endcase
        end
        // Completion overrides a same-cycle W1C of DONE
        if (w_done_rise) begin
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
        end
    end

    always_comb begin
        w_rd_data = 32'd0;
        case (w_rd_idx)
            c_IDX_STAT:  w_rd_data = {29'd0, r_err, r_done_st, r_busy};
            c_IDX_CFGK:  w_rd_data = {16'd0, r_cfg_k};
            c_IDX_IRQEN: w_rd_data = {31'd0, r_irq_en};
            c_IDX_JOB:   w_rd_data = r_job_cnt;
            default:     w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
            r_busy    <= 1'b0;
            r_done_st <= 1'b0;
            r_err     <= 1'b0;
            r_start   <= 1'b0;
            r_clr     <= 1'b0;
            r_done_q  <= 1'b0;
            r_done_q2 <= 1'b0;
            r_cfg_k   <= 16'd1;
            r_job_cnt <= 32'd0;
        end else begin
            r_awready <= ~r_awready & s_axil.awvalid & s_axil.wvalid & ~r_bvalid;
            r_wready  <= ~r_awready & s_axil.awvalid & s_axil.wvalid & ~r_bvalid;
            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_slverr ? 2'b10 : 2'b00;
            end else if (r_bvalid && s_axil.bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_rd_hs) begin
                r_rvalid  <= 1'b1;
                r_rdata   <= w_rd_data;
                r_arready <= 1'b0;
            end else if (r_rvalid && s_axil.rready) begin
                r_rvalid  <= 1'b0;
                r_arready <= 1'b1;
            end else if (!r_rvalid) begin
                r_arready <= 1'b1;
            end
            r_done_q  <= i_done;
            r_done_q2 <= r_done_q;
            r_busy    <= w_busy_nxt;
            r_done_st <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_cfg_k   <= w_cfg_k_nxt;
            r_start   <= w_start_nxt;
            r_clr     <= w_clr_nxt;
            if (w_done_rise) r_job_cnt <= r_job_cnt + 32'd1;
        end
    end

`ifdef MATMUL_CTRL_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_irq_en <= w_irq_en_nxt;
            r_irq    <= r_done_st & r_irq_en;
        end
    end
    assign o_irq = r_irq;
`else
    assign r_irq_en = 1'b0;
    assign o_irq    = 1'b0;
    logic w_unused_irq;
    assign w_unused_irq = w_irq_en_nxt;
`endif

    assign s_axil.awready = r_awready;
    assign s_axil.wready  = r_wready;
    assign s_axil.bvalid  = r_bvalid;
    assign s_axil.bresp   = r_bresp;
    assign s_axil.arready = r_arready;
    assign s_axil.rvalid  = r_rvalid;
    assign s_axil.rdata   = r_rdata;
    assign s_axil.rresp   = 2'b00;
    assign o_cfg_k         = r_cfg_k;
    assign o_start         = r_start;
    assign o_sw_clear_done = r_clr;

endmodule

`default_nettype wire
